// File: rtl/mux4_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan sequencer.
package mux4_scan_pkg;

   localparam int CH_W = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   // Next enabled channel strictly after cur, searching upward with wrap.
   // Returns cur itself when it is the only enabled channel; calling it with
   // cur = 3 yields the lowest enabled channel.
   function automatic logic [CH_W-1:0] next_chan(input logic [3:0]      mask,
                                                 input logic [CH_W-1:0] cur);
      logic [CH_W-1:0] idx;
      logic [CH_W-1:0] res;
      logic            found;
      res   = cur;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = cur + CH_W'(i);
         if (!found && mask[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux4_scan_ctrl_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module sync_fifo_fwft #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_en, rd_en;

   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   // Head is forced to zero while empty so stale entries never leak out.
   assign dout  = empty ? '0 : mem_q[rptr_q];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      rd_en  = pop && !empty;
      wr_en  = push && (!full || rd_en);
      wptr_d = wr_en ? wptr_q + AW'(1) : wptr_q;
      rptr_d = rd_en ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q;
      if (wr_en && !rd_en) cnt_d = cnt_q + (AW+1)'(1);
      if (rd_en && !wr_en) cnt_d = cnt_q - (AW+1)'(1);
   end

   // Control state with async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage array, no reset needed: content is qualified by cnt_q.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 channel mux: steps sel over enabled channels,
// waits a settle time, captures the mux output into a tagged sample FIFO.
module mux4_scan_ctrl
   import mux4_scan_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DWELL_W    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         enable_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               continuous,
   output logic [CH_W-1:0]    sel,
   input  logic [DATA_W-1:0]  mux_out,
   output logic               smp_valid,
   output logic [DATA_W-1:0]  smp_data,
   output logic [CH_W-1:0]    smp_chan,
   input  logic               smp_ready,
   output logic               busy,
   output logic               overflow
);

   state_t               state_q, state_d;
   logic [CH_W-1:0]      sel_q, sel_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [3:0]           mask_q, mask_d;
   logic                 overflow_q, overflow_d;
   logic [CH_W-1:0]      nxt_ch;
   logic                 cap_push;
   logic                 fifo_full, fifo_empty, fifo_pop;
   logic [DATA_W+CH_W-1:0] fifo_dout;

   assign fifo_pop  = !fifo_empty && smp_ready;
   assign smp_valid = !fifo_empty;
   assign smp_chan  = fifo_dout[DATA_W +: CH_W];
   assign smp_data  = fifo_dout[DATA_W-1:0];
   assign sel       = sel_q;
   assign busy      = (state_q != S_IDLE);
   assign overflow  = overflow_q;
   assign nxt_ch    = next_chan(mask_q, sel_q);

   // Next-state logic: start handling, settle countdown, capture and channel step.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      dwell_d    = dwell_q;
      mask_d     = mask_q;
      overflow_d = overflow_q;
      cap_push   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && (enable_mask != 4'b0)) begin
               mask_d     = enable_mask;
               dwell_d    = dwell;
               overflow_d = 1'b0;
               sel_d      = next_chan(enable_mask, '1);
               if (dwell != '0) begin
                  state_d = S_SETTLE;
                  cnt_d   = dwell;
               end else begin
                  state_d = S_CAPTURE;
               end
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q - DWELL_W'(1);
            if (cnt_q == DWELL_W'(1)) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            cap_push = 1'b1;
            // A wrapped search result (not above sel) means the sweep is done.
            if ((nxt_ch > sel_q) || continuous) begin
               sel_d = nxt_ch;
               if (dwell_q != '0) begin
                  state_d = S_SETTLE;
                  cnt_d   = dwell_q;
               end else begin
                  state_d = S_CAPTURE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Dropped sample: full with no simultaneous pop to make room.
      if (cap_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
   end

   // State registers with async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         cnt_q      <= '0;
         dwell_q    <= '0;
         mask_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         dwell_q    <= dwell_d;
         mask_q     <= mask_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (DATA_W + CH_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cap_push),
      .din   ({sel_q, mux_out}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl with a queue-based sample scoreboard.
module tb_mux4_scan_ctrl;

   localparam int DATA_W     = 16;
   localparam int DWELL_W    = 8;
   localparam int FIFO_DEPTH = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [3:0]         enable_mask = 4'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic               continuous = 1'b0;
   logic [1:0]         sel;
   logic [DATA_W-1:0]  mux_out;
   logic               smp_valid;
   logic [DATA_W-1:0]  smp_data;
   logic [1:0]         smp_chan;
   logic               smp_ready = 1'b0;
   logic               busy;
   logic               overflow;

   int total = 0;
   int bad = 0;
   int rx_cnt = 0;
   logic [17:0] exp_q[$];
   logic [17:0] exp_e;

   always #5 clk = ~clk;

   // Mux model: fixed per-channel values.
   always_comb begin
      case (sel)
         2'd0:    mux_out = 16'h1111;
         2'd1:    mux_out = 16'h2222;
         2'd2:    mux_out = 16'hBEEF;
         default: mux_out = 16'h4444;
      endcase
   end

   mux4_scan_ctrl #(
      .DATA_W(DATA_W), .DWELL_W(DWELL_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .enable_mask(enable_mask),
      .dwell(dwell), .continuous(continuous), .sel(sel), .mux_out(mux_out),
      .smp_valid(smp_valid), .smp_data(smp_data), .smp_chan(smp_chan),
      .smp_ready(smp_ready), .busy(busy), .overflow(overflow)
   );

   // Monitor: every accepted FIFO head is compared against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && smp_valid && smp_ready) begin
         total++;
         rx_cnt++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sample_unexpected: got chan=%0d data=%h, none expected", smp_chan, smp_data);
         end else begin
            exp_e = exp_q.pop_front();
            if ({smp_chan, smp_data} !== exp_e)
               begin
                  bad++;
                  $display("FAIL sample_order: got chan=%0d data=%h expected chan=%0d data=%h",
                           smp_chan, smp_data, exp_e[17:16], exp_e[15:0]);
               end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      ok = !busy;
   endtask

   task automatic wait_drain(input int limit, output bit ok);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      ok = (exp_q.size() == 0);
   endtask

   initial begin
      logic [1:0] sel_log [16];
      logic       ovf_log [16];
      logic       vld_log [16];
      int         bc;
      int         rx0;
      bit         ok;

      // Reset state
      tick();
      check("rst_busy", busy, 0);
      check("rst_sel", sel, 0);
      check("rst_valid", smp_valid, 0);
      check("rst_data", smp_data, 0);
      check("rst_chan", smp_chan, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      tick();

      // T1: mask 1011, no dwell, single sweep
      enable_mask = 4'b1011; dwell = 0; continuous = 0; smp_ready = 1;
      exp_q.push_back({2'd0, 16'h1111});
      exp_q.push_back({2'd1, 16'h2222});
      exp_q.push_back({2'd3, 16'h4444});
      rx0 = rx_cnt;
      start = 1'b1;
      bc = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         sel_log[i] = sel;
         vld_log[i] = smp_valid;
         if (busy) bc++;
      end
      check("t1_busy_cycles", bc, 3);
      check("t1_sel0", sel_log[0], 0);
      check("t1_sel1", sel_log[1], 1);
      check("t1_sel2", sel_log[2], 3);
      check("t1_sel_hold", sel_log[3], 3);
      check("t1_valid_before", vld_log[0], 0);
      check("t1_valid_fwft", vld_log[1], 1);
      wait_drain(20, ok);
      check("t1_drain", ok, 1);
      check("t1_samples", rx_cnt - rx0, 3);

      // T2: single channel 2 with dwell 3
      enable_mask = 4'b0100; dwell = 3;
      exp_q.push_back({2'd2, 16'hBEEF});
      rx0 = rx_cnt;
      start = 1'b1;
      bc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         sel_log[i] = sel;
         vld_log[i] = smp_valid;
         if (busy) bc++;
      end
      check("t2_busy_cycles", bc, 4);
      for (int i = 0; i < 4; i++) check("t2_sel_held", sel_log[i], 2);
      check("t2_valid_early", vld_log[3], 0);
      check("t2_valid_fwft", vld_log[4], 1);
      wait_drain(20, ok);
      check("t2_drain", ok, 1);
      check("t2_samples", rx_cnt - rx0, 1);

      // T3: continuous over all channels with consumer stalled
      enable_mask = 4'b1111; dwell = 0; continuous = 1; smp_ready = 0;
      exp_q.push_back({2'd0, 16'h1111});
      exp_q.push_back({2'd1, 16'h2222});
      exp_q.push_back({2'd2, 16'hBEEF});
      exp_q.push_back({2'd3, 16'h4444});
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) start = 1'b0;
         sel_log[i] = sel;
         ovf_log[i] = overflow;
      end
      continuous = 0;
      check("t3_sel0", sel_log[0], 0);
      check("t3_sel1", sel_log[1], 1);
      check("t3_sel2", sel_log[2], 2);
      check("t3_sel3", sel_log[3], 3);
      check("t3_sel_wrap", sel_log[4], 0);
      check("t3_ovf_at_full", ovf_log[4], 0);
      check("t3_ovf_5th", ovf_log[5], 1);
      wait_idle(20, ok);
      check("t3_idle", ok, 1);
      check("t3_ovf_sticky", overflow, 1);
      check("t3_sel_end", sel, 3);
      check("t3_valid", smp_valid, 1);

      // T4: capture into a full FIFO while the consumer pops the same cycle
      enable_mask = 4'b0001; dwell = 0; continuous = 0;
      exp_q.push_back({2'd0, 16'h1111});
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_ovf_cleared", overflow, 0);
      check("t4_busy", busy, 1);
      smp_ready = 1'b1;
      tick();
      check("t4_ovf_stays0", overflow, 0);
      check("t4_idle", busy, 0);
      wait_drain(30, ok);
      check("t4_drain", ok, 1);
      tick();
      check("t4_empty", smp_valid, 0);

      // T5: reset mid-settle with two entries queued
      smp_ready = 0;
      enable_mask = 4'b0111; dwell = 2; continuous = 0;
      start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i == 0) start = 1'b0;
      end
      check("t5_pre_valid", smp_valid, 1);
      check("t5_pre_sel", sel, 2);
      check("t5_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_valid", smp_valid, 0);
      check("t5_sel", sel, 0);
      check("t5_overflow", overflow, 0);
      check("t5_data", smp_data, 0);
      tick();
      rst_n = 1'b1;
      smp_ready = 1'b1;
      tick();

      // T6: start with empty mask, then start while busy
      rx0 = rx_cnt;
      enable_mask = 4'b0000; dwell = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6_mask0_busy", busy, 0);
      tick();
      tick();
      check("t6_mask0_valid", smp_valid, 0);
      check("t6_mask0_sel", sel, 0);
      enable_mask = 4'b0001; dwell = 2;
      exp_q.push_back({2'd0, 16'h1111});
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      enable_mask = 4'b1111; dwell = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(20, ok);
      check("t6_idle", ok, 1);
      wait_drain(20, ok);
      check("t6_drain", ok, 1);
      for (int i = 0; i < 4; i++) tick();
      check("t6_samples", rx_cnt - rx0, 1);
      check("t6_sel", sel, 0);
      check("t6_busy_end", busy, 0);
      check("final_queue", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
